// File: rtl/reg_bank_pkg.sv
// +----------------------------------------------------------------------+
// | reg_bank_pkg : shared FSM encoding and limits for reg_bank_arbiter    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package reg_bank_pkg;

  localparam int NR_REQ = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARB    = 2'd1,
    S_ACCESS = 2'd2,
    S_TURN   = 2'd3
  } state_e;

  // Write ACCESS cycles allowed without a Tick before the timeout fires.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

`default_nettype wire

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// +----------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin grant with last-served pointer          |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rr_arb2
  import reg_bank_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NR_REQ-1:0] req,
  input  logic              update,
  output logic [NR_REQ-1:0] gnt
);

  // Index of the requester served last; reset to 1 so requester 0 wins first.
  logic last_q, last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (update && (gnt != 2'b00)) last_d = gnt[1];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
// +----------------------------------------------------------------------+
// | reg_bank_arbiter : two-requester arbiter for a shared tristate bank.  |
// | Optional write timeout: define REG_BANK_ARB_TIMEOUT_EN. Revision 1.0  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NR_REGS = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Tick,
  input  logic [NR_REQ-1:0]          req,
  input  logic [NR_REQ-1:0]          wr,
  input  logic [NR_REQ*ADDR_W-1:0]   addr,
  output logic [NR_REQ-1:0]          ack,
  output logic [NR_REQ-1:0]          grant,
  output logic [NR_REGS-1:0]         cs,
  output logic [NR_REGS-1:0]         ce,
  output logic                       addr_err,
  output logic                       err
);

  localparam logic [ADDR_W:0] NR_REGS_W = (ADDR_W+1)'(NR_REGS);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NR_REQ-1:0]   arb_gnt, owner_vec;
  logic                arb_update, addr_oor;
  logic [NR_REGS-1:0]  reg_sel;

  rr_arb2 u_rr_arb2 (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    (req),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  assign owner_vec = owner_q ? 2'b10 : 2'b01;
  assign addr_oor  = ({1'b0, addr_q} >= NR_REGS_W);

  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < NR_REGS; i++) reg_sel[i] = (addr_q == ADDR_W'(i));
  end

`ifdef REG_BANK_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    arb_update = 1'b0;
    ack        = '0;
    grant      = '0;
    cs         = '1;
    ce         = '0;
    addr_err   = 1'b0;
`ifdef REG_BANK_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: if (req != 2'b00) state_d = S_ARB;
      S_ARB: begin
        grant = arb_gnt;
        if (arb_gnt != 2'b00) begin
          arb_update = 1'b1;
          owner_d    = arb_gnt[1];
          wr_d       = wr[arb_gnt[1]];
          addr_d     = arb_gnt[1] ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          state_d    = S_ACCESS;
`ifdef REG_BANK_ARB_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        grant = owner_vec;
        if (addr_oor) begin
          ack      = owner_vec;
          addr_err = 1'b1;
          state_d  = S_TURN;
        end else if (!wr_q) begin
          cs      = ~reg_sel;
          ack     = owner_vec;
          state_d = S_TURN;
        end else begin
`ifdef REG_BANK_ARB_TIMEOUT_EN
          if (cnt_q == TIMEOUT_LIMIT) begin
            ack     = owner_vec;
            err_d   = 1'b1;
            state_d = S_TURN;
          end else begin
            ce    = reg_sel;
            cnt_d = cnt_q + 8'd1;
            if (Tick) begin
              ack     = owner_vec;
              state_d = S_TURN;
            end
          end
`else
          ce = reg_sel;
          if (Tick) begin
            ack     = owner_vec;
            state_d = S_TURN;
          end
`endif
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
  end

`ifdef REG_BANK_ARB_TIMEOUT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

`default_nettype wire
